// File: rtl/insfetch.sv
// Instruction fetch front end: issues sequential/predicted fetch addresses to the
// instruction cache and buffers returned words in a small circular queue for decode.
module insfetch #(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        is_fetch,
  output logic [31:0] pc,
  input  logic        is_ret,
  input  logic [31:0] ret,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_pred,
  output logic [31:0] inst_pred_pc
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
    logic        pred;
    logic [31:0] npc;
  } entry_t;

  typedef enum logic [1:0] {S_RESET, S_RUN, S_FULL} state_t;

  state_t        state;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, cnt_nxt;
  entry_t        q [QDEPTH];

  logic        push, pop, pred;
  logic [31:0] npc, jimm, bimm;

  // FULL is exactly count==QDEPTH; RESET behaves like an empty RUN once released
  assign is_fetch = rst_in & rdy_in & ~flush_in & (state != S_FULL);
  assign push     = is_fetch & is_ret;
  assign pop      = rdy_in & ~flush_in & inst_valid & inst_ready;
  assign cnt_nxt  = count + CW'(push) - CW'(pop);

  assign jimm = {{11{ret[31]}}, ret[31], ret[19:12], ret[20], ret[30:21], 1'b0};
  assign bimm = {{19{ret[31]}}, ret[31], ret[7], ret[30:25], ret[11:8], 1'b0};

  // Static prediction: JAL and backward branches taken, everything else falls through
  always_comb begin
    npc  = pc + 32'd4;
    pred = 1'b0;
    if (ret[6:0] == OP_JAL) begin
      npc  = pc + jimm;
      pred = 1'b1;
    end else if (ret[6:0] == OP_BR && ret[31]) begin
      npc  = pc + bimm;
      pred = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= S_RESET;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        state <= S_RUN;
        pc    <= flush_pc & ~32'h1;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          pc   <= npc;
          tail <= tail + AW'(1);
        end
        if (pop) head <= head + AW'(1);
        count <= cnt_nxt;
        state <= (cnt_nxt == CW'(QDEPTH)) ? S_FULL : S_RUN;
      end
    end
  end

  // Storage is never cleared; the read side masks it while the queue is empty
  always_ff @(posedge clk_in) begin
    if (push) q[tail] <= '{word: ret, addr: pc, pred: pred, npc: npc};
  end

  assign inst_valid   = (count != '0);
  assign inst_out     = inst_valid ? q[head].word : '0;
  assign inst_pc      = inst_valid ? q[head].addr : '0;
  assign inst_pred    = inst_valid & q[head].pred;
  assign inst_pred_pc = inst_valid ? q[head].npc  : '0;

endmodule
